// File: rtl/barcode_check_serializer.sv
// Computes the parity bit and mod-10 check digit over ID_SUM plus a BCD price,
// then serialises the barcode frame (start, digits, check, parity, stop) one bit per clock.
module barcode_check_serializer #(
  parameter int NUM_DIGITS = 2,
  parameter int ID_SUM     = 54
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] valueBcd,
  output logic                    busy,
  output logic                    barOut,
  output logic                    barValid,
  output logic                    parityBit,
  output logic [3:0]              checkDigit,
  output logic                    done,
  output logic                    err
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int FRAME = VW + 11;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int IW    = $clog2(NUM_DIGITS + 1);
  localparam logic [4:0] ID_MOD10 = 5'(ID_SUM % 10);
  localparam logic       ID_PAR   = 1'(ID_SUM % 2);

  typedef enum logic [1:0] {IDLE = 2'd0, SUM = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [4:0] mod10_add(input logic [4:0] acc, input logic [3:0] d);
    logic [4:0] s;
    s = acc + {1'b0, d};
    return (s >= 5'd10) ? (s - 5'd10) : s;
  endfunction

  function automatic logic [3:0] check_of(input logic [4:0] acc);
    logic [4:0] diff;
    diff = 5'd10 - acc;
    return (acc == 5'd0) ? 4'd0 : diff[3:0];
  endfunction

  state_t          state_r, state_s;
  logic [VW-1:0]   shreg_r, shreg_s;
  logic [IW-1:0]   idx_r, idx_s;
  logic [4:0]      acc_r, acc_s;
  logic            par_r, par_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            busy_s, bar_out_s, bar_valid_s, parity_s, done_s, err_s;
  logic [3:0]      check_s;
  logic [3:0]      digit_s;
  logic [FRAME-1:0] frame_s;
  logic [CW-1:0]   bit_idx_s;

  // The shift register is rotated during SUM, so after NUM_DIGITS steps it holds the price again.
  assign digit_s   = shreg_r[VW-1 -: 4];
  assign frame_s   = {3'b101, shreg_r, checkDigit, parityBit, 3'b101};
  assign bit_idx_s = CW'(FRAME - 1) - cnt_r;

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    shreg_s     = shreg_r;
    idx_s       = idx_r;
    acc_s       = acc_r;
    par_s       = par_r;
    cnt_s       = cnt_r;
    busy_s      = busy;
    bar_out_s   = barOut;
    bar_valid_s = barValid;
    parity_s    = parityBit;
    check_s     = checkDigit;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          shreg_s = valueBcd;
          idx_s   = {IW{1'b0}};
          acc_s   = ID_MOD10;
          par_s   = ID_PAR;
          busy_s  = 1'b1;
          state_s = SUM;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SUM: begin
        if (idx_r == IW'(NUM_DIGITS)) begin
          parity_s    = par_r;
          check_s     = check_of(acc_r);
          bar_out_s   = 1'b1;
          bar_valid_s = 1'b1;
          cnt_s       = CW'(1);
          state_s     = EMIT;
        end else if (digit_s > 4'd9) begin
          err_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          acc_s   = mod10_add(acc_r, digit_s);
          par_s   = par_r ^ digit_s[0];
          shreg_s = (shreg_r << 4) | (shreg_r >> (VW - 4));
          idx_s   = idx_r + IW'(1);
        end
      end
      EMIT: begin
        if (cnt_r == CW'(FRAME)) begin
          bar_out_s   = 1'b0;
          bar_valid_s = 1'b0;
          done_s      = 1'b1;
          state_s     = DONE;
        end else begin
          bar_out_s   = frame_s[bit_idx_s];
          cnt_s       = cnt_r + CW'(1);
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s      = 1'b0;
        bar_out_s   = 1'b0;
        bar_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      shreg_r    <= {VW{1'b0}};
      idx_r      <= {IW{1'b0}};
      acc_r      <= 5'd0;
      par_r      <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      busy       <= 1'b0;
      barOut     <= 1'b0;
      barValid   <= 1'b0;
      parityBit  <= 1'b0;
      checkDigit <= 4'd0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= state_s;
      shreg_r    <= shreg_s;
      idx_r      <= idx_s;
      acc_r      <= acc_s;
      par_r      <= par_s;
      cnt_r      <= cnt_s;
      busy       <= busy_s;
      barOut     <= bar_out_s;
      barValid   <= bar_valid_s;
      parityBit  <= parity_s;
      checkDigit <= check_s;
      done       <= done_s;
      err        <= err_s;
    end
  end

endmodule

// File: tb/tb_barcode_check_serializer.sv
// Self-checking bench: table vectors, random prices against a digit-sum model,
// held-start back-to-back frames and an asynchronous reset in the middle of a frame.
module tb_barcode_check_serializer;

  localparam int N     = 2;
  localparam int IDS   = 54;
  localparam int FRAME = 4 * N + 11;
  localparam int P     = N + FRAME + 3;
  localparam int MAXW  = 64;

  logic           clk = 1'b0;
  logic           resetN, start;
  logic [4*N-1:0] valueBcd;
  logic           busy, barOut, barValid, parityBit, done, err;
  logic [3:0]     checkDigit;

  always #5 clk = ~clk;

  barcode_check_serializer #(.NUM_DIGITS(N), .ID_SUM(IDS)) dut (
    .clk(clk), .resetN(resetN), .start(start), .valueBcd(valueBcd),
    .busy(busy), .barOut(barOut), .barValid(barValid), .parityBit(parityBit),
    .checkDigit(checkDigit), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic       held_par;
  logic [3:0] held_chk;
  logic       cap_bv[MAXW], cap_bo[MAXW], cap_dn[MAXW], cap_bs[MAXW], cap_er[MAXW], cap_par[MAXW];
  logic [3:0] cap_chk[MAXW];

  typedef struct {
    logic [4*N-1:0] v;
    bit             is_err;
    logic           par;
    logic [3:0]     chk;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int digit_of(input logic [4*N-1:0] v, input int i);
    return int'((v >> (4 * (N - 1 - i))) & 4'hF);
  endfunction

  function automatic int total(input logic [4*N-1:0] v);
    int t = IDS;
    for (int i = 0; i < N; i++) t += digit_of(v, i);
    return t;
  endfunction

  function automatic int first_bad(input logic [4*N-1:0] v);
    for (int i = 0; i < N; i++) if (digit_of(v, i) > 9) return i;
    return -1;
  endfunction

  task automatic capture(input logic [4*N-1:0] v, input bit hold, input int w);
    @(negedge clk);
    start = 1'b1;
    valueBcd = v;
    for (int j = 0; j < w; j++) begin
      @(posedge clk);
      @(negedge clk);
      cap_bv[j] = barValid; cap_bo[j] = barOut; cap_dn[j] = done;
      cap_bs[j] = busy; cap_er[j] = err; cap_par[j] = parityBit; cap_chk[j] = checkDigit;
      if (!hold) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input logic [4*N-1:0] v, input int off, input string tag);
    bit q[$];
    int t, ep, ec, first, last, cnt, bad, ndone, dpos;
    t  = total(v);
    ep = t % 2;
    ec = (10 - (t % 10)) % 10;
    q = {1'b1, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) for (int b = 3; b >= 0; b--) q.push_back(bit'((digit_of(v, i) >> b) & 1));
    for (int b = 3; b >= 0; b--) q.push_back(bit'((ec >> b) & 1));
    q.push_back(bit'(ep));
    q.push_back(1'b1); q.push_back(1'b0); q.push_back(1'b1);
    first = -1; last = -1; cnt = 0; bad = 0; ndone = 0; dpos = -1;
    for (int j = off; j <= off + N + FRAME + 2; j++) begin
      if (cap_bv[j]) begin
        if (first < 0) first = j - off;
        last = j - off;
        if (cnt < FRAME && cap_bo[j] !== q[cnt]) bad++;
        cnt++;
      end else if (cap_bo[j] !== 1'b0) begin
        bad++;
      end
      if (cap_dn[j]) begin ndone++; dpos = j - off; end
    end
    chk({tag, " first_valid"}, first, N + 1);
    chk({tag, " last_valid"}, last, N + FRAME);
    chk({tag, " valid_count"}, cnt, FRAME);
    chk({tag, " frame_bits_bad"}, bad, 0);
    chk({tag, " done_count"}, ndone, 1);
    chk({tag, " done_pos"}, dpos, N + FRAME + 1);
    chk({tag, " busy_in_done"}, int'(cap_bs[off + N + FRAME + 1]), 1);
    chk({tag, " busy_after"}, int'(cap_bs[off + N + FRAME + 2]), 0);
    chk({tag, " par_before"}, int'(cap_par[off + N]), int'(held_par));
    chk({tag, " chk_before"}, int'(cap_chk[off + N]), int'(held_chk));
    chk({tag, " par_at_valid"}, int'(cap_par[off + N + 1]), ep);
    chk({tag, " chk_at_valid"}, int'(cap_chk[off + N + 1]), ec);
    held_par = 1'(ep);
    held_chk = 4'(ec);
  endtask

  task automatic check_err(input int k, input string tag);
    int nerr, epos, nvalid, stray;
    nerr = 0; epos = -1; nvalid = 0; stray = 0;
    for (int j = 0; j <= N + FRAME + 2; j++) begin
      if (cap_er[j]) begin nerr++; if (epos < 0) epos = j; end
      if (cap_bv[j]) nvalid++;
      if (cap_bo[j] !== 1'b0 || cap_dn[j] !== 1'b0) stray++;
    end
    chk({tag, " err_count"}, nerr, 1);
    chk({tag, " err_pos"}, epos, k + 1);
    chk({tag, " busy_at_err"}, int'(cap_bs[k + 1]), 0);
    chk({tag, " valid_count"}, nvalid, 0);
    chk({tag, " stray_out"}, stray, 0);
    chk({tag, " par_kept"}, int'(cap_par[N + FRAME + 2]), int'(held_par));
    chk({tag, " chk_kept"}, int'(cap_chk[N + FRAME + 2]), int'(held_chk));
  endtask

  initial begin
    logic [4*N-1:0] rv;
    int fb;
    tbl[0] = '{v: 8'h28, is_err: 1'b0, par: 1'b0, chk: 4'd6};
    tbl[1] = '{v: 8'h00, is_err: 1'b0, par: 1'b0, chk: 4'd6};
    tbl[2] = '{v: 8'h16, is_err: 1'b0, par: 1'b1, chk: 4'd9};
    tbl[3] = '{v: 8'h10, is_err: 1'b0, par: 1'b1, chk: 4'd5};
    tbl[4] = '{v: 8'h1A, is_err: 1'b1, par: 1'b1, chk: 4'd5};
    tbl[5] = '{v: 8'h99, is_err: 1'b0, par: 1'b0, chk: 4'd8};
    tbl[6] = '{v: 8'hA0, is_err: 1'b1, par: 1'b0, chk: 4'd8};

    resetN = 1'b0; start = 1'b0; valueBcd = '0;
    held_par = 1'b0; held_chk = 4'd0;
    #12;
    chk("reset_outputs", int'({busy, barOut, barValid, parityBit, checkDigit, done, err}), 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 7; i++) begin
      capture(tbl[i].v, 1'b0, N + FRAME + 3);
      if (tbl[i].is_err) check_err(first_bad(tbl[i].v), $sformatf("tbl%0d", i));
      else check_frame(tbl[i].v, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d par", i), int'(cap_par[N + FRAME + 2]), int'(tbl[i].par));
      chk($sformatf("tbl%0d chk", i), int'(cap_chk[N + FRAME + 2]), int'(tbl[i].chk));
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        rv[4*i +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      capture(rv, 1'b0, N + FRAME + 3);
      fb = first_bad(rv);
      if (fb >= 0) check_err(fb, $sformatf("rnd%0d", r));
      else check_frame(rv, 0, $sformatf("rnd%0d", r));
    end

    capture(8'h28, 1'b1, 2 * P);
    check_frame(8'h28, 0, "hold_f1");
    check_frame(8'h28, P, "hold_f2");

    @(negedge clk);
    start = 1'b1; valueBcd = 8'h37;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (N + 1 + 7 - 1) @(negedge clk);
    chk("pre_reset_valid", int'(barValid), 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_reset_outputs", int'({busy, barOut, barValid, parityBit, checkDigit, done, err}), 0);
    @(negedge clk);
    resetN = 1'b1;
    held_par = 1'b0; held_chk = 4'd0;
    capture(8'h12, 1'b0, N + FRAME + 3);
    check_frame(8'h12, 0, "post_reset");
    chk("post_reset par", int'(cap_par[N + FRAME + 2]), 1);
    chk("post_reset chk", int'(cap_chk[N + FRAME + 2]), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barcode_check_serializer.md
# barcode_check_serializer

Parametrised successor to the single-bit price-parity lookup. It accepts an N-digit BCD price and computes two check values over the team identity digit sum plus the price digits: the parity bit and a mod-10 check digit. It then serialises a complete barcode frame, one bit per clock, for the bar-drawing stage. It sits between the price-selection logic and the barcode output driver.

## Interface
- NUM_DIGITS, 2, number of BCD price digits (1..8)
- ID_SUM, 54, constant identity digit sum added before the price digits (0..255)
- clk  input  1  rising-edge clock
- resetN  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- valueBcd  input  4*NUM_DIGITS  price, BCD, most-significant digit in top nibble
- busy  output  1  high in every state except IDLE
- barOut  output  1  serial frame bit, registered
- barValid  output  1  high while barOut carries a frame bit
- parityBit  output  1  LSB of (ID_SUM + digit sum); held until next completed frame
- checkDigit  output  4  (10 − (ID_SUM + digit sum) mod 10) mod 10; held likewise
- done  output  1  one-cycle pulse after the last frame bit
- err  output  1  one-cycle pulse on an invalid BCD digit

## Operation
- States: IDLE, SUM, EMIT, DONE.
- IDLE: if start=1, latch valueBcd into a shift register. Load the running mod-10 accumulator with ID_SUM%10 and the running parity with ID_SUM%2. Go to SUM.
- SUM: process one digit per cycle, MS digit first, for NUM_DIGITS cycles.
  - Running parity ^= digit[0].
  - Running mod10 = mod10 + digit, minus 10 if the result is ≥10. The accumulator is 5 bits wide internally, and no divider is used.
  - If a digit is >9, pulse err, return to IDLE, and leave parityBit and checkDigit unchanged. No frame bits are emitted.
- On leaving SUM normally, register parityBit and checkDigit, then go to EMIT.
- EMIT frame, MSB first within each field. Frame length FRAME = 4*NUM_DIGITS + 11 bits:
  - start pattern 1,0,1
  - each price digit as 4 bits
  - checkDigit as 4 bits
  - parityBit
  - stop pattern 1,0,1
- A bit counter of width clog2(FRAME+1) selects bits. Go to DONE after the last bit.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored in SUM, EMIT and DONE.
- Reset (asynchronous, any state): state=IDLE, and busy, barOut, barValid, parityBit, checkDigit, done and err are all 0.

## Timing
- Start at edge T, sampled in IDLE. SUM then occupies cycles T+1..T+NUM_DIGITS.
- The first frame bit (with barValid=1) is valid after edge T+NUM_DIGITS+1. barValid stays high for exactly FRAME consecutive cycles.
- parityBit and checkDigit update on the same edge that raises barValid.
- done is high for the single cycle after the last frame bit. busy falls on the following edge.
- The earliest next start is sampled the cycle busy=0. Total start-to-IDLE latency is NUM_DIGITS+FRAME+2 cycles.
- For an invalid digit at SUM index k (0-based), err is high in cycle T+k+2, coincident with IDLE. barValid never rises.
- barOut=0 whenever barValid=0.

## Test plan
- NUM_DIGITS=2, ID_SUM=54, valueBcd=0x10 -> sum 55:
  - parityBit=1, checkDigit=5
  - 19-bit frame 101 0001 0000 0101 1 101
  - done 23 cycles after start
- valueBcd=0x28 -> sum 64: parityBit=0, checkDigit=6, frame 101 0010 1000 0110 0 101.
- valueBcd=0x00 -> sum 54: parityBit=0, checkDigit=6. valueBcd=0x16 -> sum 61: parityBit=1, checkDigit=9.
- valueBcd=0x1A after a good 0x10 frame:
  - err pulses 3 cycles after the start edge
  - barValid stays 0
  - parityBit=1 and checkDigit=5 are retained
- start held high throughout a frame -> exactly one frame per IDLE visit. A second frame starts only after busy=0, with no overlap and no bit drop.
- resetN driven low mid-EMIT (bit 7) -> all outputs 0 immediately, without waiting for a clock edge. After release, start with 0x12 -> clean frame with checkDigit=3 and parityBit=1.
